regfile_write_arbiter: RTL and testbench

Round-robin arbiter that shares the single write port of the 16-entry, 32-bit CalcuTEC register file among several producers: keypad entry, ALU writeback and load/immediate path. Each producer presents an address/data pair under a valid/ready handshake. The arbiter grants at most one producer per cycle and drives the register file's `reg_write`/`dir_WR`/`data_in` from a registered output stage. It also flags read-after-write hazards so decode can stall reads of registers with a write still pending.

---
 rtl/regfile_write_arbiter.sv | 111 +++++++++++
 tb/tb_regfile_write_arbiter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port among NREQ producers.
// Registered write stage feeds reg_write/dir_WR/data_in; rd_stall flags pending-write hazards.
module regfile_write_arbiter #(
  parameter int unsigned NREQ   = 3,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  input  logic [NREQ*DATA_W-1:0] req_data,
  output logic [NREQ-1:0]        req_ready,
  input  logic                   arb_hold,
  input  logic                   rd_en,
  input  logic [ADDR_W-1:0]      rd_dirA,
  input  logic [ADDR_W-1:0]      rd_dirB,
  output logic                   rd_stall,
  output logic                   rf_reg_write,
  output logic [ADDR_W-1:0]      rf_dir_wr,
  output logic [DATA_W-1:0]      rf_data_in,
  output logic [2:0]             grant_id
);

  logic [2:0]        ptr_q, ptr_d;
  logic [2:0]        win;
  logic              found;
  logic              xfer;
  logic [7:0]        valid_pad;
  logic [3:0]        sum;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic              hit;

  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [2:0]        id_q;

  // Search upward from ptr, wrapping at NREQ; first valid requester wins.
  always_comb begin
    valid_pad            = '0;
    valid_pad[NREQ-1:0]  = req_valid;
    found                = 1'b0;
    win                  = '0;
    sum                  = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      sum = {1'b0, ptr_q} + 4'(k);
      if (sum >= 4'(NREQ)) begin
        sum = sum - 4'(NREQ);
      end
      if (!found && valid_pad[sum[2:0]]) begin
        found = 1'b1;
        win   = sum[2:0];
      end
    end
  end

  assign xfer  = found & ~arb_hold & rst_n;
  assign ptr_d = (win == 3'(NREQ - 1)) ? 3'd0 : win + 3'd1;

  always_comb begin
    req_ready = '0;
    sel_addr  = '0;
    sel_data  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      req_ready[i] = xfer && (win == 3'(i));
      if (win == 3'(i)) begin
        sel_addr = req_addr[i*ADDR_W +: ADDR_W];
        sel_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Output stage is excluded: its write lands before the next read samples the file.
  always_comb begin
    hit = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (req_valid[i] && (req_addr[i*ADDR_W +: ADDR_W] == rd_dirA ||
                           req_addr[i*ADDR_W +: ADDR_W] == rd_dirB)) begin
        hit = 1'b1;
      end
    end
  end

  assign rd_stall = rd_en & hit;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q  <= '0;
      wr_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      id_q   <= '0;
    end else begin
      wr_q <= xfer;
      if (xfer) begin
        ptr_q  <= ptr_d;
        addr_q <= sel_addr;
        data_q <= sel_data;
        id_q   <= win;
      end
    end
  end

  assign rf_reg_write = wr_q;
  assign rf_dir_wr    = addr_q;
  assign rf_data_in   = data_q;
  assign grant_id     = id_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomized + directed bench for regfile_write_arbiter with a queue-based scoreboard.
module tb_regfile_write_arbiter;
  localparam int NREQ = 3;
  localparam int AW   = 4;
  localparam int DW   = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              arb_hold;
  logic              rd_en;
  logic [AW-1:0]     rd_dirA;
  logic [AW-1:0]     rd_dirB;
  logic              rd_stall;
  logic              rf_reg_write;
  logic [AW-1:0]     rf_dir_wr;
  logic [DW-1:0]     rf_data_in;
  logic [2:0]        grant_id;

  always #5 clk = ~clk;

  regfile_write_arbiter #(
    .NREQ   (NREQ),
    .ADDR_W (AW),
    .DATA_W (DW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_addr     (req_addr),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .arb_hold     (arb_hold),
    .rd_en        (rd_en),
    .rd_dirA      (rd_dirA),
    .rd_dirB      (rd_dirB),
    .rd_stall     (rd_stall),
    .rf_reg_write (rf_reg_write),
    .rf_dir_wr    (rf_dir_wr),
    .rf_data_in   (rf_data_in),
    .grant_id     (grant_id)
  );

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int            id;
    int            cyc;
  } wr_t;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  wr_t  sb[$];
  int   gorder[$];

  // Reference state: what each requester is presenting, the fair pointer, the file contents.
  bit            pend_v [NREQ];
  logic [AW-1:0] pend_a [NREQ];
  logic [DW-1:0] pend_d [NREQ];
  bit            keep   [NREQ];
  int            mptr;
  logic [DW-1:0] model_rf [16];
  logic [DW-1:0] tb_rf    [16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]         = pend_v[i];
      req_addr[i*AW +: AW] = pend_a[i];
      req_data[i*DW +: DW] = pend_d[i];
    end
  endtask

  task automatic step();
    int              w;
    logic [NREQ-1:0] er;
    bit              es;
    drive();
    #1;
    w = -1;
    for (int k = 0; k < NREQ; k++) begin
      if (w < 0 && pend_v[(mptr + k) % NREQ]) w = (mptr + k) % NREQ;
    end
    er = '0;
    if (w >= 0 && !arb_hold) er[w] = 1'b1;
    es = 1'b0;
    if (rd_en) begin
      for (int i = 0; i < NREQ; i++) begin
        if (pend_v[i] && (pend_a[i] == rd_dirA || pend_a[i] == rd_dirB)) es = 1'b1;
      end
    end
    chk("req_ready", 64'(req_ready), 64'(er));
    chk("rd_stall", 64'(rd_stall), 64'(es));
    if (er != '0) begin
      sb.push_back('{a: pend_a[w], d: pend_d[w], id: w, cyc: cyc + 1});
      model_rf[pend_a[w]] = pend_d[w];
      mptr = (w + 1) % NREQ;
      gorder.push_back(w);
      if (keep[w]) begin
        pend_a[w] = AW'($urandom);
        pend_d[w] = $urandom;
      end else begin
        pend_v[w] = 1'b0;
      end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic request(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    pend_v[i] = 1'b1;
    pend_a[i] = a;
    pend_d[i] = d;
  endtask

  // Monitor: each registered write must match the oldest scoreboard entry, one cycle after grant.
  initial begin
    wr_t e;
    forever begin
      @(posedge clk);
      #2;
      if (rf_reg_write === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write actual=1 required=0 addr=%0h (cycle %0d)", rf_dir_wr, cyc);
        end else begin
          e = sb.pop_front();
          chk("wr_addr", 64'(rf_dir_wr), 64'(e.a));
          chk("wr_data", 64'(rf_data_in), 64'(e.d));
          chk("wr_id", 64'(grant_id), 64'(e.id));
          chk("wr_cycle", 64'(cyc), 64'(e.cyc));
        end
        tb_rf[rf_dir_wr] = rf_data_in;
      end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        checks++;
        errors++;
        $display("FAIL missing_write actual=0 required=1 addr=%0h (cycle %0d)", e.a, cyc);
      end
    end
  end

  initial begin
    for (int r = 0; r < 16; r++) begin
      model_rf[r] = '0;
      tb_rf[r]    = '0;
    end
    for (int i = 0; i < NREQ; i++) begin
      keep[i] = 1'b0;
      request(i, AW'(i), $urandom);
    end
    mptr     = 0;
    rst_n    = 1'b0;
    arb_hold = 1'b0;
    rd_en    = 1'b0;
    rd_dirA  = '0;
    rd_dirB  = '0;
    drive();

    // Reset with every requester valid
    @(negedge clk);
    repeat (3) begin
      #1;
      chk("reset_ready", 64'(req_ready), 64'(0));
      @(posedge clk);
      cyc++;
      #1;
      chk("reset_out", {27'(0), rf_reg_write, rf_dir_wr, rf_data_in, grant_id}, 64'(0));
      @(negedge clk);
    end
    rst_n = 1'b1;
    repeat (3) step();
    chk("first_grant", 64'(gorder[0]), 64'(0));

    // Single write from requester 1
    request(1, 4'd5, 32'hDEADBEEF);
    step();
    step();
    chk("single_idle", 64'(rf_reg_write), 64'(0));
    chk("single_rf5", 64'(tb_rf[5]), 64'(32'hDEADBEEF));

    // Round-robin, starting from ptr 0
    request(2, 4'd0, $urandom);
    step();
    gorder.delete();
    for (int i = 0; i < NREQ; i++) begin
      keep[i] = 1'b1;
      request(i, AW'($urandom), $urandom);
    end
    repeat (6) step();
    for (int k = 0; k < 6; k++) chk("rr_order", 64'(gorder[k]), 64'(k % 3));
    keep[1]   = 1'b0;
    pend_v[1] = 1'b0;
    gorder.delete();
    repeat (4) step();
    for (int k = 0; k < 4; k++) chk("rr_drop1", 64'(gorder[k]), 64'((k % 2) * 2));
    for (int i = 0; i < NREQ; i++) begin
      keep[i]   = 1'b0;
      pend_v[i] = 1'b0;
    end

    // Hold
    gorder.delete();
    request(2, 4'd11, $urandom);
    arb_hold = 1'b1;
    repeat (4) begin
      step();
      chk("hold_no_write", 64'(rf_reg_write), 64'(0));
    end
    chk("hold_no_grant", 64'(gorder.size()), 64'(0));
    arb_hold = 1'b0;
    step();
    chk("hold_release", 64'(gorder.size()), 64'(1));
    step();

    // Hazard
    request(0, 4'd7, $urandom);
    rd_en    = 1'b1;
    rd_dirA  = 4'd1;
    rd_dirB  = 4'd7;
    arb_hold = 1'b1;
    drive();
    #1;
    chk("haz_pending_held", 64'(rd_stall), 64'(1));
    step();
    arb_hold = 1'b0;
    step();
    drive();
    #1;
    chk("haz_out_stage", 64'(rd_stall), 64'(0));
    chk("haz_out_addr", 64'(rf_dir_wr), 64'(7));
    rd_dirA = 4'd3;
    rd_dirB = 4'd3;
    step();
    rd_en = 1'b0;

    // Same-address collision from ptr 0
    request(2, 4'd0, $urandom);
    step();
    gorder.delete();
    request(0, 4'd9, 32'h1111);
    request(2, 4'd9, 32'h2222);
    step();
    step();
    step();
    chk("coll_first", 64'(gorder[0]), 64'(0));
    chk("coll_second", 64'(gorder[1]), 64'(2));
    chk("coll_rf9", 64'(tb_rf[9]), 64'(32'h2222));

    // Random traffic
    repeat (400) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pend_v[i] && ($urandom % 2 == 0)) request(i, AW'($urandom), $urandom);
      end
      arb_hold = ($urandom % 8 == 0);
      rd_en    = $urandom % 2;
      rd_dirA  = AW'($urandom);
      rd_dirB  = AW'($urandom);
      step();
    end
    arb_hold = 1'b0;
    repeat (NREQ + 2) step();

    chk("sb_empty", 64'(sb.size()), 64'(0));
    for (int r = 0; r < 16; r++) chk("rf_final", 64'(tb_rf[r]), 64'(model_rf[r]));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
